// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the GMII transmit arbiter.
// Source indices, default timing and the arbiter FSM encoding.
package eth_tx_pkg;

   localparam int N_REQ              = 3;
   localparam int IDX_W              = 2;
   localparam int IFG_CYCLES_DEF     = 12;
   localparam int TIMEOUT_CYCLES_DEF = 4096;

   localparam logic [IDX_W-1:0] SRC_ARP  = 2'd0;
   localparam logic [IDX_W-1:0] SRC_ICMP = 2'd1;
   localparam logic [IDX_W-1:0] SRC_UDP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      BUSY  = 2'd2,
      IFG   = 2'd3
   } state_e;

   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      for (int i = 0; i < N_REQ; i++) begin
         oh[i] = (idx == IDX_W'(i));
      end
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending source after ptr, wrapping.
// The source at ptr itself is checked last.
module rr_pick
   import eth_tx_pkg::*;
(
   input  logic [N_REQ-1:0] pending,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] winner
);

   // Scan ptr+1, ptr+2, ... and keep only the first hit.
   always_comb begin
      int   idx;
      logic hit;
      valid  = 1'b0;
      winner = {IDX_W{1'b0}};
      idx    = 0;
      hit    = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx    = (int'(ptr) + k) % N_REQ;
         hit    = ~valid & pending[idx];
         winner = hit ? IDX_W'(idx) : winner;
         valid  = valid | hit;
      end
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares one GMII transmit port between ARP, ICMP and UDP transmitters:
// latches start requests, grants round-robin, forwards the winner and enforces the IFG.
module eth_tx_arbiter
   import eth_tx_pkg::*;
#(
   parameter int IFG_CYCLES     = IFG_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_REQ-1:0]     req_start,
   output logic [N_REQ-1:0]     grant_start,
   input  logic [N_REQ-1:0]     src_tx_en,
   input  logic [8*N_REQ-1:0]   src_txd,
   input  logic [N_REQ-1:0]     src_tx_done,
   output logic                 gmii_tx_en,
   output logic [7:0]           gmii_txd,
   output logic [IDX_W-1:0]     grant_id,
   output logic                 busy,
   output logic                 timeout_err
);

   state_e             state_q, state_d;
   logic [N_REQ-1:0]   pending_q, pending_d;
   logic [N_REQ-1:0]   grant_start_q, grant_start_d;
   logic [IDX_W-1:0]   ptr_q, ptr_d;
   logic [IDX_W-1:0]   grant_id_q, grant_id_d;
   logic [15:0]        wd_q, wd_d;
   logic [15:0]        ifg_q, ifg_d;
   logic               gmii_en_q, gmii_en_d;
   logic [7:0]         gmii_txd_q, gmii_txd_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic               pick_valid_s;
   logic [IDX_W-1:0]   pick_idx_s;
   logic [N_REQ-1:0]   pick_oh_s;
   logic [N_REQ-1:0]   gnt_oh_s;
   logic               sel_en_s;
   logic               sel_done_s;
   logic [7:0]         sel_txd_s;

   rr_pick u_rr_pick (
      .pending (pending_q),
      .ptr     (ptr_q),
      .valid   (pick_valid_s),
      .winner  (pick_idx_s)
   );

   assign pick_oh_s = idx_to_onehot(pick_idx_s);
   assign gnt_oh_s  = idx_to_onehot(grant_id_q);

   // Forward only the granted source; the others are masked off entirely.
   always_comb begin
      sel_en_s   = 1'b0;
      sel_done_s = 1'b0;
      sel_txd_s  = 8'h00;
      for (int i = 0; i < N_REQ; i++) begin
         sel_en_s   = sel_en_s   | (src_tx_en[i]   & gnt_oh_s[i]);
         sel_done_s = sel_done_s | (src_tx_done[i] & gnt_oh_s[i]);
         sel_txd_s  = sel_txd_s  | (src_txd[8*i +: 8] & {8{gnt_oh_s[i]}});
      end
   end

   // Next-state logic for the arbiter FSM, request latches, watchdog and IFG timer.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q | req_start;
      ptr_d         = ptr_q;
      grant_id_d    = grant_id_q;
      grant_start_d = {N_REQ{1'b0}};
      wd_d          = wd_q;
      ifg_d         = ifg_q;
      timeout_d     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid_s) begin
               ptr_d         = pick_idx_s;
               grant_id_d    = pick_idx_s;
               pending_d     = (pending_q & ~pick_oh_s) | req_start;
               grant_start_d = pick_oh_s;
               state_d       = GRANT;
            end else begin
               state_d       = IDLE;
            end
         end
         GRANT: begin
            wd_d    = 16'd0;
            state_d = BUSY;
         end
         BUSY: begin
            // Done has priority; the watchdog trips as it steps onto TIMEOUT_CYCLES-1.
            if (sel_done_s) begin
               ifg_d   = 16'd0;
               state_d = IFG;
            end else if (wd_q == 16'(TIMEOUT_CYCLES - 2)) begin
               timeout_d = 1'b1;
               ifg_d     = 16'd0;
               state_d   = IFG;
            end else begin
               wd_d = wd_q + 16'd1;
            end
         end
         IFG: begin
            if (ifg_q == 16'(IFG_CYCLES - 1)) begin
               state_d = IDLE;
            end else begin
               ifg_d = ifg_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if ((state_q == GRANT) || (state_q == BUSY)) begin
         gmii_en_d  = sel_en_s;
         gmii_txd_d = sel_txd_s;
      end else begin
         gmii_en_d  = 1'b0;
         gmii_txd_d = 8'h00;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pending_q     <= {N_REQ{1'b0}};
         ptr_q         <= IDX_W'(N_REQ - 1);
         grant_id_q    <= {IDX_W{1'b0}};
         grant_start_q <= {N_REQ{1'b0}};
         wd_q          <= 16'd0;
         ifg_q         <= 16'd0;
         gmii_en_q     <= 1'b0;
         gmii_txd_q    <= 8'h00;
         busy_q        <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         ptr_q         <= ptr_d;
         grant_id_q    <= grant_id_d;
         grant_start_q <= grant_start_d;
         wd_q          <= wd_d;
         ifg_q         <= ifg_d;
         gmii_en_q     <= gmii_en_d;
         gmii_txd_q    <= gmii_txd_d;
         busy_q        <= busy_d;
         timeout_q     <= timeout_d;
      end
   end

   assign grant_start = grant_start_q;
   assign gmii_tx_en  = gmii_en_q;
   assign gmii_txd    = gmii_txd_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign timeout_err = timeout_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: stimulus queues expected grants, gmii bytes
// and watchdog pulses with their cycle stamps; a negedge monitor pops and compares.
module tb_eth_tx_arbiter;
   import eth_tx_pkg::*;

   localparam int TO  = 64;
   localparam int IFG_N = 12;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [N_REQ-1:0]     req_start;
   logic [N_REQ-1:0]     grant_start;
   logic [N_REQ-1:0]     src_tx_en;
   logic [8*N_REQ-1:0]   src_txd;
   logic [N_REQ-1:0]     src_tx_done;
   logic                 gmii_tx_en;
   logic [7:0]           gmii_txd;
   logic [IDX_W-1:0]     grant_id;
   logic                 busy;
   logic                 timeout_err;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct { logic [N_REQ-1:0] oh; int cyc; } gexp_t;
   typedef struct { logic [7:0] b; int cyc; } dexp_t;
   gexp_t gq[$];
   dexp_t dq[$];
   int    tq[$];

   eth_tx_arbiter #(.IFG_CYCLES(IFG_N), .TIMEOUT_CYCLES(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_start   (req_start),
      .grant_start (grant_start),
      .src_tx_en   (src_tx_en),
      .src_txd     (src_txd),
      .src_tx_done (src_tx_done),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .grant_id    (grant_id),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard monitor: every DUT event must match the head of its queue, cycle included.
   always @(negedge clk) begin
      gexp_t ge;
      dexp_t de;
      int    tc;
      if (grant_start != '0) begin
         checks++;
         if (gq.size() == 0) begin
            errors++;
            $display("FAIL grant_unexpected: got %b at cycle %0d, required no grant", grant_start, cyc);
         end else begin
            ge = gq.pop_front();
            if (grant_start !== ge.oh || cyc != ge.cyc) begin
               errors++;
               $display("FAIL grant: got %b at cycle %0d, required %b at cycle %0d", grant_start, cyc, ge.oh, ge.cyc);
            end
         end
      end
      if (gmii_tx_en) begin
         checks++;
         if (dq.size() == 0) begin
            errors++;
            $display("FAIL gmii_unexpected: got txd %h at cycle %0d, required tx_en=0", gmii_txd, cyc);
         end else begin
            de = dq.pop_front();
            if (gmii_txd !== de.b || cyc != de.cyc) begin
               errors++;
               $display("FAIL gmii_data: got %h at cycle %0d, required %h at cycle %0d", gmii_txd, cyc, de.b, de.cyc);
            end
         end
      end
      if (timeout_err) begin
         checks++;
         if (tq.size() == 0) begin
            errors++;
            $display("FAIL timeout_unexpected: got pulse at cycle %0d, required none", cyc);
         end else begin
            tc = tq.pop_front();
            if (cyc != tc) begin
               errors++;
               $display("FAIL timeout_cycle: got cycle %0d, required cycle %0d", cyc, tc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_start = '0; src_tx_en = '0; src_txd = '0; src_tx_done = '0;
      tick(2);
      rst = 1'b0;
   endtask

   // Pulse req_start for one cycle and return the request cycle.
   task automatic pulse_req(input logic [N_REQ-1:0] m, output int t);
      t = cyc;
      req_start = m;
      tick(1);
      req_start = '0;
   endtask

   // Drive a frame from src starting in the grant cycle; optional intruder and extra request.
   task automatic run_frame(input int src, input int len, input logic [7:0] base, input int bad,
                            input logic [N_REQ-1:0] rmask, input int rk, output int d);
      d = cyc;
      for (int k = 0; k < len; k++) begin
         src_tx_en = '0; src_txd = '0; src_tx_done = '0;
         src_tx_en[src] = 1'b1;
         src_txd[8*src +: 8] = base + 8'(k);
         src_tx_done[src] = (k == len - 1);
         if (bad >= 0) begin
            src_tx_en[bad] = 1'b1;
            src_txd[8*bad +: 8] = 8'hAA;
            src_tx_done[bad] = (k == 1);
         end
         req_start = (k == rk) ? rmask : '0;
         dq.push_back('{b: base + 8'(k), cyc: cyc + 1});
         if (k == len - 1) d = cyc;
         tick(1);
      end
      src_tx_en = '0; src_txd = '0; src_tx_done = '0; req_start = '0;
   endtask

   initial begin
      int t, g, d, d2;
      rst = 1'b1;
      req_start = '0; src_tx_en = '0; src_txd = '0; src_tx_done = '0;
      tick(1);

      // 1: reset state, single ICMP request, IFG length
      rst = 1'b1;
      tick(2);
      chk("rst_gmii_tx_en", 32'(gmii_tx_en), 32'd0);
      chk("rst_gmii_txd", 32'(gmii_txd), 32'd0);
      chk("rst_grant_start", 32'(grant_start), 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      rst = 1'b0;
      tick(1);
      pulse_req(3'b010, t);
      gq.push_back('{oh: 3'b010, cyc: t + 2});
      wait_until(t + 2);
      chk("t1_grant_id", 32'(grant_id), 32'(SRC_ICMP));
      chk("t1_busy_grant", 32'(busy), 32'd1);
      run_frame(1, 5, 8'h10, -1, '0, -1, d);
      wait_until(d + 12);
      chk("t1_busy_ifg_end", 32'(busy), 32'd1);
      tick(1);
      chk("t1_busy_idle", 32'(busy), 32'd0);
      tick(3);

      // 2: all three request together -> 0,1,2 with IFG between
      do_reset();
      pulse_req(3'b111, t);
      gq.push_back('{oh: 3'b001, cyc: t + 2});
      wait_until(t + 2);
      chk("t2_grant_id0", 32'(grant_id), 32'(SRC_ARP));
      run_frame(0, 4, 8'h20, -1, '0, -1, d);
      gq.push_back('{oh: 3'b010, cyc: d + 14});
      wait_until(d + 14);
      run_frame(1, 3, 8'h30, -1, '0, -1, d);
      gq.push_back('{oh: 3'b100, cyc: d + 14});
      wait_until(d + 14);
      chk("t2_grant_id2", 32'(grant_id), 32'(SRC_UDP));
      run_frame(2, 6, 8'h40, -1, '0, -1, d);
      wait_until(d + 14);
      chk("t2_busy_end", 32'(busy), 32'd0);

      // 3: ICMP re-requests during its own frame while UDP waits -> 1,2,1
      do_reset();
      pulse_req(3'b010, t);
      gq.push_back('{oh: 3'b010, cyc: t + 2});
      wait_until(t + 2);
      run_frame(1, 6, 8'h50, -1, 3'b110, 2, d);
      gq.push_back('{oh: 3'b100, cyc: d + 14});
      wait_until(d + 14);
      run_frame(2, 3, 8'h60, -1, '0, -1, d2);
      gq.push_back('{oh: 3'b010, cyc: d2 + 14});
      wait_until(d2 + 14);
      run_frame(1, 3, 8'h70, -1, '0, -1, d);
      wait_until(d + 14);
      chk("t3_busy_end", 32'(busy), 32'd0);

      // 4: ARP never finishes -> watchdog release, then ICMP served
      do_reset();
      pulse_req(3'b011, t);
      g = t + 2;
      gq.push_back('{oh: 3'b001, cyc: g});
      tq.push_back(g + TO);
      gq.push_back('{oh: 3'b010, cyc: g + TO + 13});
      wait_until(g + TO - 1);
      chk("t4_busy_before_timeout", 32'(busy), 32'd1);
      wait_until(g + TO + 13);
      run_frame(1, 3, 8'h80, -1, '0, -1, d);
      wait_until(d + 14);
      chk("t4_busy_end", 32'(busy), 32'd0);

      // 5: UDP drives en/data/done while ARP owns the port
      do_reset();
      pulse_req(3'b001, t);
      gq.push_back('{oh: 3'b001, cyc: t + 2});
      wait_until(t + 2);
      run_frame(0, 6, 8'h90, 2, '0, -1, d);
      wait_until(d + 12);
      chk("t5_busy_ifg_end", 32'(busy), 32'd1);
      tick(1);
      chk("t5_busy_idle", 32'(busy), 32'd0);

      // 6: reset mid-frame drops the frame and the pending ICMP request
      do_reset();
      pulse_req(3'b001, t);
      g = t + 2;
      gq.push_back('{oh: 3'b001, cyc: g});
      wait_until(g);
      for (int k = 0; k < 3; k++) begin
         src_tx_en = 3'b001;
         src_txd = '0;
         src_txd[7:0] = 8'hB0 + 8'(k);
         req_start = (k == 1) ? 3'b010 : 3'b000;
         dq.push_back('{b: 8'hB0 + 8'(k), cyc: cyc + 1});
         tick(1);
      end
      rst = 1'b1;
      src_tx_en = '0; src_txd = '0; req_start = '0;
      tick(1);
      chk("t6_gmii_en_after_rst", 32'(gmii_tx_en), 32'd0);
      chk("t6_busy_after_rst", 32'(busy), 32'd0);
      rst = 1'b0;
      tick(6);
      chk("t6_no_stale_grant", 32'(busy), 32'd0);
      pulse_req(3'b100, t);
      gq.push_back('{oh: 3'b100, cyc: t + 2});
      wait_until(t + 2);
      chk("t6_grant_id", 32'(grant_id), 32'(SRC_UDP));
      run_frame(2, 3, 8'hC0, -1, '0, -1, d);
      wait_until(d + 14);
      chk("t6_busy_end", 32'(busy), 32'd0);

      chk("grant_queue_empty", 32'(gq.size()), 32'd0);
      chk("gmii_queue_empty", 32'(dq.size()), 32'd0);
      chk("timeout_queue_empty", 32'(tq.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not reach the end");
      $fatal(1);
   end

endmodule
